// File: rtl/mdio_register_bank.sv
// Register bank fronting CHANNELS independent MDIO engines: per-channel command
// issue/track FSM with timeout, read-data capture, sticky W1C status and one interrupt.
module mdio_register_bank #(
  parameter int CHANNELS = 2,
  parameter int TIMEOUT  = 4096,
  parameter int AW       = $clog2(CHANNELS * 4)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [AW-1:0]            addr,
  input  logic                     wr_en,
  input  logic [31:0]              wr_data,
  input  logic                     rd_en,
  output logic [31:0]              rd_data,
  output logic                     rd_valid,
  output logic [CHANNELS-1:0]      cmd_valid,
  input  logic [CHANNELS-1:0]      cmd_ready,
  output logic [32*CHANNELS-1:0]   cmd_data,
  input  logic [CHANNELS-1:0]      rsp_valid,
  input  logic [16*CHANNELS-1:0]   rsp_data,
  output logic                     irq
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  logic [31:0]         a_ext;
  logic [1:0]          off;
  logic [31:0]         rd_word [CHANNELS];
  logic [CHANNELS-1:0] irq_src;
  logic [31:0]         rd_next;

  // Zero-extending first keeps decode valid even when AW is only 2 bits wide.
  assign a_ext = 32'(addr);
  assign off   = a_ext[1:0];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t       state;
    logic         cv;
    logic [31:0]  word;
    logic [15:0]  rdata;
    logic         rxv;
    logic         done;
    logic         ovr;
    logic         tmo;
    logic [2:0]   en;
    logic [CW-1:0] cnt;

    logic wr_hit, rd_hit, cmd_wr, st_wr, en_wr, rd_rdata;
    logic rsp_take, rd_rsp, to_hit, idle;

    assign wr_hit   = wr_en && (a_ext[31:2] == 30'(c));
    assign rd_hit   = rd_en && (a_ext[31:2] == 30'(c));
    assign cmd_wr   = wr_hit && (off == 2'd0);
    assign st_wr    = wr_hit && (off == 2'd2);
    assign en_wr    = wr_hit && (off == 2'd3);
    assign rd_rdata = rd_hit && (off == 2'd1);
    assign idle     = (state == IDLE);
    assign rsp_take = (state == WAIT) && rsp_valid[c];
    assign rd_rsp   = rsp_take && (word[29:28] == 2'b10);
    assign to_hit   = (state == WAIT) && !rsp_valid[c] && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state <= IDLE;
        cv    <= 1'b0;
        word  <= '0;
        rdata <= '0;
        rxv   <= 1'b0;
        done  <= 1'b0;
        ovr   <= 1'b0;
        tmo   <= 1'b0;
        en    <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: if (cmd_wr) begin
            state <= ISSUE;
            word  <= wr_data;
            cv    <= 1'b1;
          end
          ISSUE: if (cmd_ready[c]) begin
            state <= WAIT;
            cnt   <= '0;
            cv    <= 1'b0;
          end
          WAIT: begin
            if (rsp_valid[c] || to_hit) state <= IDLE;
            else                        cnt   <= cnt + 1'b1;
          end
          default: begin
            state <= IDLE;
            cv    <= 1'b0;
          end
        endcase
        if (rd_rsp) rdata <= rsp_data[16*c +: 16];
        if (en_wr)  en    <= wr_data[5:3];
        // Hardware sets are OR-ed in after the clear so a same-cycle set always wins.
        rxv  <= (rxv  && !rd_rdata) || rd_rsp;
        done <= (done && !(st_wr && wr_data[3])) || rsp_take;
        ovr  <= (ovr  && !(st_wr && wr_data[4])) || (cmd_wr && !idle) || (rd_rsp && rxv);
        tmo  <= (tmo  && !(st_wr && wr_data[5])) || to_hit;
      end
    end

    assign cmd_valid[c]          = cv;
    assign cmd_data[32*c +: 32]  = word;
    assign irq_src[c]            = |({tmo, ovr, done} & en);

    always_comb begin
      rd_word[c] = '0;
      case (off)
        2'd1:    rd_word[c] = {16'd0, rdata};
        2'd2:    rd_word[c] = {26'd0, tmo, ovr, done, !idle, rxv, idle};
        2'd3:    rd_word[c] = {26'd0, en, 3'd0};
        default: rd_word[c] = '0;
      endcase
    end
  end

  always_comb begin
    rd_next = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (a_ext[31:2] == 30'(c)) rd_next = rd_word[c];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      irq      <= 1'b0;
    end else begin
      rd_data  <= rd_en ? rd_next : '0;
      rd_valid <= rd_en;
      irq      <= |irq_src;
    end
  end

endmodule

// File: tb/tb_mdio_register_bank.sv
// Bench for mdio_register_bank: register vector table, directed corner sequences
// and randomized traffic, all scored against a cycle-level behavioural model.
module tb_mdio_register_bank;
  localparam int CH = 3;
  localparam int TO = 16;
  localparam int AW = $clog2(CH * 4);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [AW-1:0]     addr = '0;
  logic              wr_en = 1'b0;
  logic [31:0]       wr_data = '0;
  logic              rd_en = 1'b0;
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic [CH-1:0]     cmd_valid;
  logic [CH-1:0]     cmd_ready = '0;
  logic [32*CH-1:0]  cmd_data;
  logic [CH-1:0]     rsp_valid = '0;
  logic [16*CH-1:0]  rsp_data = '0;
  logic              irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mdio_register_bank #(.CHANNELS(CH), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a channel is either holding a command for the engine,
  // waiting (with its age in cycles) for the answer, or free.
  bit          m_pend [CH];
  bit          m_wait [CH];
  int          m_age  [CH];
  logic [31:0] m_word [CH];
  logic [15:0] m_rdat [CH];
  bit          m_rxv  [CH];
  bit          m_done [CH];
  bit          m_ovr  [CH];
  bit          m_tmo  [CH];
  bit [2:0]    m_en   [CH];
  logic [31:0] m_rd;
  bit          m_rdv;
  bit          m_irq;

  function automatic logic [31:0] m_status(input int c);
    bit busy;
    busy = m_pend[c] || m_wait[c];
    return {26'd0, m_tmo[c], m_ovr[c], m_done[c], busy, m_rxv[c], !busy};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_pend[c] = 0; m_wait[c] = 0; m_age[c] = 0; m_word[c] = '0; m_rdat[c] = '0;
      m_rxv[c] = 0; m_done[c] = 0; m_ovr[c] = 0; m_tmo[c] = 0; m_en[c] = '0;
    end
    m_rd = '0; m_rdv = 0; m_irq = 0;
  endtask

  task automatic model_step();
    int a, ch, off;
    logic [31:0] nrd;
    bit nirq;
    a = int'(addr); ch = a / 4; off = a % 4;
    nrd = '0;
    if (rd_en && ch < CH) begin
      if (off == 1) nrd = {16'd0, m_rdat[ch]};
      if (off == 2) nrd = m_status(ch);
      if (off == 3) nrd = {26'd0, m_en[ch], 3'd0};
    end
    nirq = 0;
    for (int c = 0; c < CH; c++)
      if (({m_tmo[c], m_ovr[c], m_done[c]} & m_en[c]) != 3'd0) nirq = 1;
    for (int c = 0; c < CH; c++) begin
      bit w, free, got, rdresp, expire, ovr_set;
      w       = wr_en && (ch == c);
      free    = !m_pend[c] && !m_wait[c];
      got     = m_wait[c] && rsp_valid[c];
      rdresp  = got && (m_word[c][29:28] == 2'b10);
      expire  = m_wait[c] && !rsp_valid[c] && (m_age[c] == TO - 1);
      ovr_set = (w && off == 0 && !free) || (rdresp && m_rxv[c]);
      if (m_pend[c] && cmd_ready[c]) begin
        m_pend[c] = 0; m_wait[c] = 1; m_age[c] = 0;
      end else if (m_wait[c]) begin
        if (got || expire) m_wait[c] = 0;
        else m_age[c] = m_age[c] + 1;
      end
      if (w && off == 0 && free) begin
        m_pend[c] = 1; m_word[c] = wr_data;
      end
      if (rdresp) m_rdat[c] = rsp_data[c*16 +: 16];
      if (rd_en && ch == c && off == 1) m_rxv[c] = 0;
      if (rdresp) m_rxv[c] = 1;
      if (w && off == 2) begin
        if (wr_data[3]) m_done[c] = 0;
        if (wr_data[4]) m_ovr[c] = 0;
        if (wr_data[5]) m_tmo[c] = 0;
      end
      if (got) m_done[c] = 1;
      if (ovr_set) m_ovr[c] = 1;
      if (expire) m_tmo[c] = 1;
      if (w && off == 3) m_en[c] = wr_data[5:3];
    end
    m_rd = nrd; m_rdv = rd_en; m_irq = nirq;
  endtask

  always @(negedge reset) model_reset();

  always @(posedge clk) begin
    if (reset) model_step();
    #1;
    check("rd_valid", {31'd0, rd_valid}, {31'd0, m_rdv});
    if (m_rdv) check("rd_data", rd_data, m_rd);
    check("irq", {31'd0, irq}, {31'd0, m_irq});
    for (int c = 0; c < CH; c++) begin
      check("cmd_valid", {31'd0, cmd_valid[c]}, {31'd0, m_pend[c]});
      check("cmd_data", cmd_data[c*32 +: 32], m_word[c]);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic bus_wr(input int a, input logic [31:0] d);
    addr = AW'(a); wr_data = d; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic bus_rd(input int a, output logic [31:0] d);
    addr = AW'(a); rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    d = rd_data;
  endtask

  typedef struct {
    bit            wr;
    bit            rd;
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [31:0]   exp;
  } vec_t;

  vec_t tbl[$];
  logic [31:0] d;

  initial begin
    model_reset();
    #1 reset = 1'b0;
    repeat (3) step();
    check("reset_cmd_valid", {29'd0, cmd_valid}, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    reset = 1'b1;
    step();

    // Register-level vectors: {wr, rd, addr, wdata, expected read data}
    tbl.push_back('{1'b0, 1'b1, AW'(2),  32'd0,         32'h01});
    tbl.push_back('{1'b0, 1'b1, AW'(6),  32'd0,         32'h01});
    tbl.push_back('{1'b0, 1'b1, AW'(10), 32'd0,         32'h01});
    tbl.push_back('{1'b0, 1'b1, AW'(3),  32'd0,         32'h00});
    tbl.push_back('{1'b1, 1'b0, AW'(3),  32'hFFFF_FFFF, 32'h00});
    tbl.push_back('{1'b0, 1'b1, AW'(3),  32'd0,         32'h38});
    tbl.push_back('{1'b1, 1'b1, AW'(7),  32'h18,        32'h00});
    tbl.push_back('{1'b0, 1'b1, AW'(7),  32'd0,         32'h18});
    tbl.push_back('{1'b0, 1'b1, AW'(12), 32'd0,         32'h00});
    tbl.push_back('{1'b1, 1'b0, AW'(14), 32'hFFFF_FFFF, 32'h00});
    tbl.push_back('{1'b0, 1'b1, AW'(14), 32'd0,         32'h00});
    tbl.push_back('{1'b0, 1'b1, AW'(15), 32'd0,         32'h00});
    tbl.push_back('{1'b0, 1'b1, AW'(0),  32'd0,         32'h00});
    tbl.push_back('{1'b0, 1'b1, AW'(1),  32'd0,         32'h00});
    tbl.push_back('{1'b0, 1'b1, AW'(8),  32'd0,         32'h00});
    tbl.push_back('{1'b1, 1'b0, AW'(2),  32'hFFFF_FFFF, 32'h00});
    tbl.push_back('{1'b0, 1'b1, AW'(2),  32'd0,         32'h01});
    tbl.push_back('{1'b1, 1'b0, AW'(3),  32'd0,         32'h00});
    tbl.push_back('{1'b1, 1'b0, AW'(7),  32'd0,         32'h00});
    for (int i = 0; i < tbl.size(); i++) begin
      addr = tbl[i].a; wr_data = tbl[i].d; wr_en = tbl[i].wr; rd_en = tbl[i].rd;
      step();
      wr_en = 1'b0; rd_en = 1'b0;
      if (tbl[i].rd) check($sformatf("vec%0d", i), rd_data, tbl[i].exp);
    end

    // Read command on channel 0
    bus_wr(0, 32'h6000_0000);
    check("c0_cmd_valid", {31'd0, cmd_valid[0]}, 32'd1);
    check("c0_cmd_data", cmd_data[31:0], 32'h6000_0000);
    step(); step();
    cmd_ready[0] = 1'b1; step(); cmd_ready[0] = 1'b0;
    check("c0_valid_drop", {31'd0, cmd_valid[0]}, 32'd0);
    bus_rd(2, d); check("c0_busy", d, 32'h04);
    repeat (3) step();
    rsp_data[15:0] = 16'hBEEF; rsp_valid[0] = 1'b1; step(); rsp_valid[0] = 1'b0;
    bus_rd(2, d); check("c0_status_done", d, 32'h0B);
    bus_rd(1, d); check("c0_rdata", d, 32'h0000_BEEF);
    bus_rd(2, d); check("c0_rx_cleared", d, 32'h09);
    bus_wr(2, 32'h08);
    bus_rd(2, d); check("c0_w1c", d, 32'h01);

    // Overrun on channel 1
    bus_wr(4, 32'h5123_4567);
    bus_wr(4, 32'hAAAA_5555);
    check("c1_first_word", cmd_data[63:32], 32'h5123_4567);
    bus_rd(6, d); check("c1_overrun", d, 32'h14);
    bus_wr(7, 32'h10);
    check("c1_irq_latency", {31'd0, irq}, 32'd0);
    step();
    check("c1_irq", {31'd0, irq}, 32'd1);
    cmd_ready[1] = 1'b1; step(); cmd_ready[1] = 1'b0;
    rsp_data[31:16] = 16'h7777; rsp_valid[1] = 1'b1; step(); rsp_valid[1] = 1'b0;
    bus_rd(6, d); check("c1_write_done", d, 32'h19);
    bus_rd(5, d); check("c1_no_capture", d, 32'h0);
    bus_wr(6, 32'h38); bus_wr(7, 32'h0);
    bus_rd(6, d); check("c1_cleared", d, 32'h01);
    check("c1_irq_off", {31'd0, irq}, 32'd0);

    // Timeout on channel 0: exactly TO cycles in WAIT
    bus_wr(0, 32'h6000_1234);
    cmd_ready[0] = 1'b1; step(); cmd_ready[0] = 1'b0;
    repeat (TO - 1) step();
    bus_rd(2, d); check("to_last_wait", d, 32'h04);
    bus_rd(2, d); check("to_expired", d, 32'h21);
    rsp_data[15:0] = 16'h5555; rsp_valid[0] = 1'b1; step(); rsp_valid[0] = 1'b0;
    bus_rd(1, d); check("to_late_rdata", d, 32'h0000_BEEF);
    bus_rd(2, d); check("to_late_status", d, 32'h21);
    bus_wr(2, 32'h20);

    // RDATA read colliding with a read response
    bus_wr(0, 32'h6000_0000);
    cmd_ready[0] = 1'b1; step(); cmd_ready[0] = 1'b0;
    step();
    addr = AW'(1); rd_en = 1'b1; rsp_data[15:0] = 16'h5678; rsp_valid[0] = 1'b1;
    step();
    rd_en = 1'b0; rsp_valid[0] = 1'b0;
    check("col_read_old", rd_data, 32'h0000_BEEF);
    bus_rd(2, d); check("col_rx_kept", d, 32'h0B);
    bus_rd(1, d); check("col_rdata_new", d, 32'h0000_5678);
    bus_wr(2, 32'h38);
    // W1C of done colliding with done being set
    bus_wr(0, 32'h1000_0000);
    cmd_ready[0] = 1'b1; step(); cmd_ready[0] = 1'b0;
    step();
    addr = AW'(2); wr_data = 32'h08; wr_en = 1'b1; rsp_valid[0] = 1'b1;
    step();
    wr_en = 1'b0; rsp_valid[0] = 1'b0;
    bus_rd(2, d); check("col_set_wins", d, 32'h09);
    bus_wr(2, 32'h38);

    // Parallel channels answering in the same cycle
    bus_wr(0, 32'h6000_0000);
    bus_wr(4, 32'h6000_0001);
    cmd_ready[1:0] = 2'b11; step(); cmd_ready[1:0] = 2'b00;
    step();
    rsp_data[31:0] = 32'h2222_1111; rsp_valid[1:0] = 2'b11; step(); rsp_valid[1:0] = 2'b00;
    bus_rd(1, d); check("par_c0", d, 32'h0000_1111);
    bus_rd(5, d); check("par_c1", d, 32'h0000_2222);
    bus_rd(8, d); check("par_addr8", d, 32'h0);
    check("par_addr8_valid", {31'd0, rd_valid}, 32'd1);
    bus_rd(12, d); check("par_out_of_range", d, 32'h0);

    // Reset mid-ISSUE
    bus_wr(0, 32'h6000_0000);
    check("rst_issue", {31'd0, cmd_valid[0]}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_async_valid", {29'd0, cmd_valid}, 32'd0);
    check("rst_async_data", cmd_data[31:0], 32'd0);
    step(); step();
    reset = 1'b1;
    step();
    for (int c = 0; c < CH; c++) begin
      bus_rd(4 * c + 2, d);
      check($sformatf("rst_status%0d", c), d, 32'h01);
    end

    // Randomized traffic scored by the model
    for (int n = 0; n < 3000; n++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      rd_en   = ($urandom_range(0, 2) == 0);
      addr    = AW'($urandom_range(0, 15));
      wr_data = $urandom;
      for (int c = 0; c < CH; c++) begin
        cmd_ready[c] = ($urandom_range(0, 2) == 0);
        rsp_valid[c] = ($urandom_range(0, 11) == 0);
      end
      rsp_data = {$urandom, $urandom};
      step();
    end
    wr_en = 1'b0; rd_en = 1'b0; cmd_ready = '0; rsp_valid = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdio_register_bank.md
Name: mdio_register_bank

Overview:
- Multi-channel, parametrised register bank between the generic bus register adapter and CHANNELS independent MDIO engines.
- Per channel, it issues commands with a valid/ready handshake and tracks each command through to its response, with a timeout.
- Captures read data and keeps sticky done, overrun and timeout status bits, cleared by write-1-to-clear.
- Drives one combined, maskable interrupt. Replaces the single-channel, status-only mapping.

Parameters:
- CHANNELS, 2, number of MDIO engines (1..8).
- TIMEOUT, 4096, cycles allowed in WAIT before a command is aborted (>=2).
- AW, $clog2(CHANNELS*4), register address width (derived; do not override).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- addr  in  AW  register address. Channel c owns addresses 4c..4c+3.
- wr_en  in  1  register write strobe.
- wr_data  in  32  write data.
- rd_en  in  1  register read strobe.
- rd_data  out  32  read data, registered.
- rd_valid  out  1  high exactly one cycle after rd_en.
- cmd_valid  out  CHANNELS  per-channel command valid.
- cmd_ready  in  CHANNELS  per-channel engine accept.
- cmd_data  out  32*CHANNELS  command word, channel c at [32c+31:32c].
- rsp_valid  in  CHANNELS  one-cycle response pulse from the engine.
- rsp_data  in  16*CHANNELS  response data, channel c at [16c+15:16c].
- irq  out  1  level interrupt.

Behaviour:
- Reset (async assert, sync deassert via clk): all outputs 0, all registers 0, all channels in IDLE.

Register map, per channel at base 4c:
- +0 CMD (write). Format [31:30] ST, [29:28] OP, [27:16] PHY/REG/TA, [15:0] data.
- +1 RDATA (read). [15:0] last read data.
- +2 STATUS. bit0 tx_ready (= state==IDLE, live), bit1 rx_valid, bit2 busy (= state!=IDLE), bit3 done, bit4 overrun, bit5 timeout. Bits 3..5 are sticky and W1C.
- +3 IRQ_EN (read/write). [5:3] enable bits for done, overrun and timeout.
- Unused bits read 0. Addresses >= 4*CHANNELS: reads return 0, writes are ignored.

Bus timing:
- rd_data and rd_valid are registered: 1-cycle latency.
- Read side effects occur in the rd_en cycle.
- wr_en and rd_en in the same cycle are both honoured. The read returns the pre-write value.

Per-channel FSM:
- IDLE -> ISSUE on a CMD write. The command word is latched into cmd_data.
- ISSUE: cmd_valid=1 and cmd_data held stable until cmd_ready. On the cycle cmd_valid&cmd_ready -> WAIT, the timeout counter clears and cmd_valid drops next cycle.
- WAIT -> IDLE on rsp_valid. This sets done. If the latched OP==2'b10 (read), RDATA <= rsp_data and rx_valid is set.
- WAIT -> IDLE when the counter reaches TIMEOUT-1 with no response. This sets timeout; done stays clear.

Boundary cases:
- CMD write while not IDLE: command dropped, overrun set, FSM unaffected.
- Read response while rx_valid is already 1: RDATA overwritten, overrun set.
- rsp_valid in IDLE or ISSUE (including a late response after timeout): ignored entirely.
- Reading RDATA clears rx_valid. If a read response lands in the same cycle, rx_valid stays 1 and the new data is kept.
- W1C in the same cycle as a hardware set of the same bit: set wins.
- Channels are fully independent. Simultaneous events on different channels never interact.
- irq = OR over all channels of (STATUS[5:3] & IRQ_EN[5:3]). It is registered, so it updates 1 cycle after the causing event.
- reset asserted mid-command: cmd_valid drops immediately (async) and the in-flight command is discarded.

Test Plan:
- Read, channel 0: write CMD 0x6000_0000 (OP=10). Expect cmd_valid and cmd_data=0x6000_0000; cmd_ready after 3 cycles; rsp_valid with 0xBEEF 5 cycles later. Then STATUS=0x0B and RDATA=0xBEEF. Reading RDATA returns 0xBEEF, and STATUS then reads 0x09. W1C 0x08 -> STATUS=0x01.
- Overrun, channel 1 (CHANNELS=2): write CMD, write CMD again while busy. STATUS bit4=1; only the first word is seen on cmd_data[63:32]; IRQ_EN=0x10 -> irq=1 one cycle later.
- Timeout (TIMEOUT=16): accept the command and give no rsp_valid. After exactly 16 WAIT cycles STATUS=0x21. A late rsp_valid leaves RDATA and STATUS unchanged.
- Collisions: read RDATA in the same cycle as a read response. rx_valid stays 1 and RDATA holds the new value. Write W1C 0x08 in the same cycle as done sets: done remains 1.
- Parallel channels: both channels busy, responses in the same cycle with 0x1111/0x2222. Each RDATA is correct. Address 8 reads 0 with rd_valid=1.
- reset: pulse reset low mid-ISSUE. cmd_valid=0 asynchronously; all STATUS registers=0x01 after release.
